mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit
Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath width; all data ports are WORD_SIZE bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 10, data-memory word-address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum BUSY cycles waiting for dmem_ack.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ex_valid  in  1  EX/MEM stage holds a valid instruction.
REQ-007 SHALL have port alu_result  in  32  byte address for loads/stores; writeback value otherwise.
REQ-008 SHALL have port rdata2  in  32  store data.
REQ-009 SHALL have port funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port rd  in  5  destination register.
REQ-011 SHALL have port en_write_reg  in  1  instruction writes the regfile.
REQ-012 SHALL have port mem_read  in  1  load.
REQ-013 SHALL have port mem_write  in  1  store.
REQ-014 SHALL have port write_source  in  1  1 = writeback from memory, 0 = from alu_result.
REQ-015 SHALL have port stall  out  1  hold EX/MEM and earlier stages.
REQ-016 SHALL have port dmem_req  out  1  memory request valid.
REQ-017 SHALL have port dmem_we  out  1  1 = write.
REQ-018 SHALL have port dmem_addr  out  ADDR_SIZE  word address = alu_result[ADDR_SIZE+1:2].
REQ-019 SHALL have port dmem_wdata  out  32  store data shifted to byte lane.
REQ-020 SHALL have port dmem_wstrb  out  4  byte enables.
REQ-021 SHALL have port dmem_rdata  in  32  read word, valid with dmem_ack.
REQ-022 SHALL have port dmem_ack  in  1  one-cycle completion pulse.
REQ-023 SHALL have port wb_valid  out  1  MEM/WB entry valid.
REQ-024 SHALL have port wb_rd  out  5  registered rd.
REQ-025 SHALL have port wb_en_write_reg  out  1  registered write enable, forced 0 on fault.
REQ-026 SHALL have port wb_data  out  32  registered writeback value.
REQ-027 SHALL have port mem_fault  out  1  one-cycle pulse: misaligned, mem_read&mem_write both set, or timeout.
Function
REQ-028 SHALL implement FSM IDLE/BUSY; mem op = ex_valid & (mem_read | mem_write).
REQ-029 In IDLE, non-mem valid op SHALL load wb_* next edge (wb_data = alu_result), latency 1, stall 0.
REQ-030 In IDLE, legal aligned mem op SHALL assert stall combinationally, latch address/data/strobe/funct3/rd, enter BUSY.
REQ-031 In BUSY, dmem_req SHALL be 1 with stable dmem_we/addr/wdata/wstrb until dmem_ack; stall = ~dmem_ack.
REQ-032 On dmem_ack in BUSY, SHALL load wb_* next edge, return IDLE; ack-to-ack minimum load latency 2 cycles.
REQ-033 Load data SHALL be selected by alu_result[1:0]: B/H sign-extended, BU/HU zero-extended, W unchanged; wb_data = loaded value if write_source else alu_result.
REQ-034 Store: SB wstrb = 0001<<off, data byte replicated; SH wstrb = 0011<<off, half replicated; SW wstrb = 1111.
REQ-035 Misaligned (H with off[0]=1, W with off!=0) or mem_read&mem_write SHALL pulse mem_fault, issue no request, not stall, write wb_valid=1, wb_en_write_reg=0.
REQ-036 BUSY counter SHALL count cycles; at TIMEOUT cycles without ack, SHALL pulse mem_fault, drop dmem_req, write wb_en_write_reg=0, return IDLE.
REQ-037 dmem_ack in IDLE SHALL be ignored; ack in same cycle as timeout expiry SHALL count as success.
REQ-038 wb_valid SHALL be 0 on any cycle with no completion (idle bubble, BUSY wait).
REQ-039 funct3 codes 011/110/111 on mem op SHALL be treated as W.
Reset
REQ-040 On rst, next edge: state IDLE, counter 0, dmem_req 0, wb_valid 0, wb_en_write_reg 0, wb_rd 0, wb_data 0, mem_fault 0, dmem_we 0, dmem_wstrb 0.
REQ-041 rst during BUSY SHALL abandon the access without fault; late ack after reset ignored.
Verification
REQ-042 ALU op alu_result=0x1234, rd=5, en=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, stall never 1.
REQ-043 LB addr 0x003, ack after 3 BUSY cycles with rdata 0x80FF_FF00 -> stall 4 cycles, wb_data=0xFFFF_FF80.
REQ-044 SH addr 0x006, rdata2=0xABCD -> dmem_addr=1, wstrb=1100, wdata=0xABCD_ABCD, dmem_we=1.
REQ-045 LW addr 0x002 -> mem_fault pulse, dmem_req stays 0, wb_en_write_reg=0, stall 0.
REQ-046 LW with no ack -> dmem_req high 16 cycles, then mem_fault, IDLE; rst asserted mid-BUSY in a rerun -> dmem_req 0 next cycle, no fault.

---
 rtl/mem_access_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: EX/MEM load/store unit with byte-lane alignment, ack handshake and timeout fault
module mem_access_unit #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 10,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic [WORD_SIZE-1:0] alu_result,
    input  logic [WORD_SIZE-1:0] rdata2,
    input  logic [2:0]           funct3,
    input  logic [4:0]           rd,
    input  logic                 en_write_reg,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 write_source,
    output logic                 stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    output logic [WORD_SIZE-1:0] dmem_wdata,
    output logic [3:0]           dmem_wstrb,
    input  logic [WORD_SIZE-1:0] dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 wb_valid,
    output logic [4:0]           wb_rd,
    output logic                 wb_en_write_reg,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic                 mem_fault
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt;
    logic [2:0]           f3_q;
    logic [1:0]           off_q;
    logic [4:0]           rd_q;
    logic                 en_q, ws_q;
    logic [WORD_SIZE-1:0] alu_q;
    logic [1:0]           off;
    logic                 mem_op, misaligned, bad, go, done, expire;
    logic [3:0]           wstrb;
    logic [WORD_SIZE-1:0] wdata, shifted, load;

    // funct3[1] set means word access, which also covers the 011/110/111 codes
    assign off        = alu_result[1:0];
    assign mem_op     = ex_valid & (mem_read | mem_write);
    assign misaligned = funct3[1] ? (off != 2'b00) : (funct3[0] & off[0]);
    assign bad        = mem_op & ((mem_read & mem_write) | misaligned);
    assign go         = mem_op & ~bad;
    assign done       = (state == BUSY) & dmem_ack;
    assign expire     = (state == BUSY) & ~dmem_ack & (cnt == LAST);
    assign wstrb      = funct3[1] ? 4'b1111 : ((funct3[0] ? 4'b0011 : 4'b0001) << off);
    assign wdata      = funct3[1] ? rdata2 :
                        funct3[0] ? {(WORD_SIZE/16){rdata2[15:0]}} : {(WORD_SIZE/8){rdata2[7:0]}};
    assign shifted    = dmem_rdata >> {off_q, 3'b000};
    assign load       = f3_q[1] ? dmem_rdata :
                        f3_q[0] ? {{(WORD_SIZE-16){~f3_q[2] & shifted[15]}}, shifted[15:0]} :
                                  {{(WORD_SIZE-8){~f3_q[2] & shifted[7]}}, shifted[7:0]};

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state, request and stall; a timeout releases the stall in its final cycle
    always_comb begin
        state_n  = state;
        stall    = 1'b0;
        dmem_req = 1'b0;
        if (state == IDLE) begin
            stall   = go;
            state_n = go ? BUSY : IDLE;
        end else begin
            dmem_req = 1'b1;
            stall    = ~dmem_ack & ~expire;
            state_n  = (dmem_ack | expire) ? IDLE : BUSY;
        end
    end

    // request latch, BUSY cycle counter and MEM/WB register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            dmem_wstrb      <= 4'b0000;
            f3_q            <= 3'b000;
            off_q           <= 2'b00;
            rd_q            <= 5'd0;
            en_q            <= 1'b0;
            ws_q            <= 1'b0;
            alu_q           <= '0;
            wb_valid        <= 1'b0;
            wb_rd           <= 5'd0;
            wb_en_write_reg <= 1'b0;
            wb_data         <= '0;
            mem_fault       <= 1'b0;
        end else begin
            cnt <= (state == BUSY) ? cnt + 1'b1 : '0;
            if (state == IDLE && go) begin
                dmem_we    <= mem_write;
                dmem_addr  <= alu_result[ADDR_SIZE+1:2];
                dmem_wdata <= wdata;
                dmem_wstrb <= wstrb;
                f3_q       <= funct3;
                off_q      <= off;
                rd_q       <= rd;
                en_q       <= en_write_reg;
                ws_q       <= write_source;
                alu_q      <= alu_result;
            end
            if (state == IDLE) begin
                wb_valid        <= ex_valid & ~go;
                wb_rd           <= rd;
                wb_en_write_reg <= ex_valid & en_write_reg & ~bad & ~go;
                wb_data         <= alu_result;
                mem_fault       <= bad;
            end else begin
                wb_valid        <= done | expire;
                wb_rd           <= rd_q;
                wb_en_write_reg <= done & en_q;
                wb_data         <= (done & ws_q) ? load : alu_q;
                mem_fault       <= expire;
            end
        end
    end
endmodule
